// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and
// the predicates the hazard unit uses to build its stall term.
package md_pkg;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdOp_e;

    // Any instruction that enters the unit; it must wait while the unit is busy.
    function automatic logic is_md_start(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
               (op == MD_DIVU) || (op == MD_MTHI)  || (op == MD_MTLO);
    endfunction

    // MFHI/MFLO read HI/LO and must not overtake an in-flight operation.
    function automatic logic is_md_read(input logic isMfhi, input logic isMflo);
        return isMfhi || isMflo;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero
// flag; an iterative divider can later replace this behind the same interface.
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MD_OP_W-1:0]  op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [2*WIDTH-1:0]  result,
    output logic                div0
);

    logic               isSigned;
    logic [2*WIDTH-1:0] extA;
    logic [2*WIDTH-1:0] extB;
    logic [2*WIDTH-1:0] product;
    logic               negA;
    logic               negB;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   safeB;
    logic [WIDTH-1:0]   quoMag;
    logic [WIDTH-1:0]   remMag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               bZero;

    assign isSigned = (op == MD_MULT) || (op == MD_DIV);

    // Sign- or zero-extended 2W multiply: the low 2W bits are the exact product.
    assign extA    = isSigned ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign extB    = isSigned ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign product = extA * extB;

    // Magnitude division then sign fix-up; -2^(W-1)/-1 wraps back to -2^(W-1).
    assign negA   = isSigned && a[WIDTH-1];
    assign negB   = isSigned && b[WIDTH-1];
    assign magA   = negA ? -a : a;
    assign magB   = negB ? -b : b;
    assign bZero  = (b == '0);
    assign safeB  = bZero ? {{(WIDTH-1){1'b0}}, 1'b1} : magB;
    assign quoMag = magA / safeB;
    assign remMag = magA % safeB;
    assign quo    = (negA ^ negB) ? -quoMag : quoMag;
    assign rem    = negA ? -remMag : remMag;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: result = product;
            MD_DIV, MD_DIVU: begin
                result = {rem, quo};
                div0   = bZero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: holds HI/LO, runs a latency counter that drives
// busy, and commits the pending result when the counter expires.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               cancel,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] pending;
    logic               commitEn;
    logic [2*WIDTH-1:0] arithResult;
    logic               arithDiv0;
    logic               accept;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (md_op),
        .a      (src_a),
        .b      (src_b),
        .result (arithResult),
        .div0   (arithDiv0)
    );

    assign busy   = (cnt != '0);
    assign accept = start && !busy && !cancel;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            pending  <= '0;
            commitEn <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (cancel) begin
            cnt <= '0;
        end else if (accept) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    pending  <= arithResult;
                    commitEn <= 1'b1;
                    cnt      <= CNT_W'(MULT_CYCLES);
                end
                MD_DIV, MD_DIVU: begin
                    pending  <= arithResult;
                    commitEn <= !arithDiv0;
                    cnt      <= CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi <= src_a;
                MD_MTLO: lo <= src_a;
                default: ;
            endcase
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            // Final count: a divide by zero still burns its cycles but leaves HI/LO alone.
            if (cnt == CNT_W'(1) && commitEn) begin
                hi <= pending[2*WIDTH-1:WIDTH];
                lo <= pending[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latencies, signed/unsigned results,
// MTHI/MTLO, divide by zero, cancel and asynchronous reset.
module tb_md_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic               clk;
    logic               reset;
    logic               start;
    logic [MD_OP_W-1:0] mdOp;
    logic [W-1:0]       srcA;
    logic [W-1:0]       srcB;
    logic               cancel;
    logic               busy;
    logic [W-1:0]       hi;
    logic [W-1:0]       lo;

    int nChecks = 0;
    int nErrors = 0;
    int cycles;

    md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (mdOp),
        .src_a  (srcA),
        .src_b  (srcB),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents one start for a single edge, returns at the next negedge.
    task automatic issue(input logic [MD_OP_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges with busy high, bounded so a stuck busy shows up as a wrong count.
    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        mdOp   = MD_MULT;
        srcA   = '0;
        srcB   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: signed multiply, with no early commit on the first busy cycle
        issue(MD_MULT, -32'sd3, 32'd7);
        check("mult_busy_first", busy, 1);
        check("mult_no_early_lo", lo, 0);
        waitIdle(cycles);
        check("mult_busy_cycles", cycles, 5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);

        // 2: unsigned multiply, started in the cycle busy falls
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        waitIdle(cycles);
        check("multu_busy_cycles", cycles, 5);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // 3: signed / unsigned divide and the signed overflow case
        issue(MD_DIV, -32'sd7, 32'd2);
        waitIdle(cycles);
        check("div_busy_cycles", cycles, 10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        issue(MD_DIVU, -32'sd7, 32'd2);
        waitIdle(cycles);
        check("divu_lo", lo, 32'h7FFFFFFC);
        check("divu_hi", hi, 32'h1);
        issue(MD_DIV, 32'd7, -32'sd2);
        waitIdle(cycles);
        check("div_negb_lo", lo, 32'hFFFFFFFD);
        check("div_negb_hi", hi, 32'h1);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(cycles);
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h0);

        // 4: MTHI/MTLO take effect at once, then divide by zero leaves them intact
        issue(MD_MTLO, 32'h1234, 32'd0);
        check("mtlo_lo", lo, 32'h1234);
        check("mtlo_busy", busy, 0);
        issue(MD_MTHI, 32'hABCD, 32'd0);
        check("mthi_hi", hi, 32'hABCD);
        check("mthi_busy", busy, 0);
        issue(MD_DIV, 32'd5, 32'd0);
        waitIdle(cycles);
        check("div0_busy_cycles", cycles, 10);
        check("div0_lo", lo, 32'h1234);
        check("div0_hi", hi, 32'hABCD);

        // Unknown op and start while busy have no effect
        issue(3'd7, 32'h5555, 32'h1);
        check("unknown_busy", busy, 0);
        check("unknown_lo", lo, 32'h1234);
        issue(MD_MULT, 32'd3, 32'd3);
        issue(MD_MTLO, 32'hDEAD, 32'd0);
        check("start_while_busy_lo", lo, 32'h1234);
        waitIdle(cycles);
        check("busy_mult_cycles", cycles, 4);
        check("busy_mult_lo", lo, 32'd9);
        check("busy_mult_hi", hi, 32'd0);

        // 5: cancel at busy cycle 4 of a divide, then an immediate restart
        issue(MD_MTHI, 32'hABCD, 32'd0);
        issue(MD_MTLO, 32'h1234, 32'd0);
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        repeat (10) @(negedge clk);
        check("cancel_hi", hi, 32'hABCD);
        check("cancel_lo", lo, 32'h1234);
        issue(MD_DIV, 32'd100, 32'd7);
        waitIdle(cycles);
        check("restart_cycles", cycles, 10);
        check("restart_lo", lo, 32'd14);
        check("restart_hi", hi, 32'd2);

        // cancel beats start, and beats the final commit edge
        mdOp   = MD_MTLO;
        srcA   = 32'hBEEF;
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_vs_start_lo", lo, 32'd14);
        check("cancel_vs_start_busy", busy, 0);
        issue(MD_MULTU, 32'd1000, 32'd1000);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_last_busy", busy, 0);
        check("cancel_last_lo", lo, 32'd14);
        check("cancel_last_hi", hi, 32'd2);

        // 6: asynchronous reset at busy cycle 3 of a multiply
        issue(MD_MULT, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_hi", hi, 0);
        check("async_rst_lo", lo, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_lo", lo, 0);
        check("post_rst_hi", hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrors);
        $finish;
    end

endmodule
